// File: rtl/program_loader.sv
// Packs big-endian UART byte pairs into instruction words and writes them to program memory.
// Optional build macro LOADER_OPCODE_CHECK_EN: refuse words whose opcode is undefined (> 7).
module program_loader #(
    parameter int NB_OPCODE      = 5,
    parameter int NB_OPERAND     = 11,
    parameter int NB_INSTRUCTION = 16,
    parameter int NB_DATA        = 8,
    parameter int NB_ADDR        = 11
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_rx_done,
    input  logic [NB_DATA-1:0]        i_rx_data,
    output logic                      o_pm_wr_en,
    output logic [NB_ADDR-1:0]        o_pm_addr,
    output logic [NB_INSTRUCTION-1:0] o_pm_data,
    output logic                      o_busy,
    output logic                      o_load_done,
    output logic                      o_error
);

    // state   | meaning
    // WAIT_HI | waiting for the high byte of the next word
    // WAIT_LO | high byte latched, waiting for the low byte
    // DONE    | HALT written, CPU released, input ignored until reset
    // ERROR   | memory full or undefined opcode, input ignored until reset
    typedef enum logic [1:0] {
        WAIT_HI = 2'd0,
        WAIT_LO = 2'd1,
        DONE    = 2'd2,
        ERROR   = 2'd3
    } state_t;

    state_t                      state, next_state;
    logic [NB_DATA-1:0]          hi_byte, hi_byte_d;
    logic [NB_ADDR-1:0]          count, count_d;
    logic                        wr_en_d;
    logic [NB_ADDR-1:0]          addr_d;
    logic [NB_INSTRUCTION-1:0]   data_d;
    logic                        busy, busy_d;
    logic [NB_INSTRUCTION-1:0]   word;
    logic [NB_OPCODE-1:0]        opcode;
    logic                        bad_opcode;
    logic                        last_location;

    assign word          = {hi_byte, i_rx_data};
    assign opcode        = word[NB_OPERAND +: NB_OPCODE];
    assign last_location = (count == {NB_ADDR{1'b1}});

`ifdef LOADER_OPCODE_CHECK_EN
    assign bad_opcode = (opcode > NB_OPCODE'(7));
`else
    assign bad_opcode = 1'b0;
`endif

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state      <= WAIT_HI;
            hi_byte    <= '0;
            count      <= '0;
            o_pm_wr_en <= 1'b0;
            o_pm_addr  <= '0;
            o_pm_data  <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= next_state;
            hi_byte    <= hi_byte_d;
            count      <= count_d;
            o_pm_wr_en <= wr_en_d;
            o_pm_addr  <= addr_d;
            o_pm_data  <= data_d;
            busy       <= busy_d;
        end
    end

    always_comb begin
        next_state = state;
        hi_byte_d  = hi_byte;
        count_d    = count;
        wr_en_d    = 1'b0;
        addr_d     = o_pm_addr;
        data_d     = o_pm_data;
        busy_d     = busy;
        case (state)
            WAIT_HI: begin
                if (i_rx_done) begin
                    hi_byte_d  = i_rx_data;
                    busy_d     = 1'b1;
                    next_state = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (i_rx_done) begin
                    if (bad_opcode) begin
                        busy_d     = 1'b0;
                        next_state = ERROR;
                    end else begin
                        wr_en_d = 1'b1;
                        addr_d  = count;
                        data_d  = word;
                        if (opcode == '0) begin
                            busy_d     = 1'b0;
                            next_state = DONE;
                        end else if (last_location) begin
                            // counter is left at the top address; it never wraps
                            busy_d     = 1'b0;
                            next_state = ERROR;
                        end else begin
                            count_d    = count + NB_ADDR'(1);
                            next_state = WAIT_HI;
                        end
                    end
                end
            end
            DONE:    next_state = DONE;
            ERROR:   next_state = ERROR;
            default: next_state = WAIT_HI;
        endcase
    end

    assign o_busy      = busy;
    assign o_load_done = (state == DONE);
    assign o_error     = (state == ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: cycle-level vector table on the default build, plus
// randomized word streams on a 4-deep instance checked against a list-level model.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_done;
    logic [7:0]  rx_data;

    logic        a_wr, a_busy, a_done, a_err;
    logic [10:0] a_addr;
    logic [15:0] a_data;
    logic        b_wr, b_busy, b_done, b_err;
    logic [1:0]  b_addr;
    logic [15:0] b_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    program_loader dut_a (
        .i_clock(clk), .i_reset(rst_n), .i_rx_done(rx_done), .i_rx_data(rx_data),
        .o_pm_wr_en(a_wr), .o_pm_addr(a_addr), .o_pm_data(a_data),
        .o_busy(a_busy), .o_load_done(a_done), .o_error(a_err)
    );

    program_loader #(.NB_ADDR(2)) dut_b (
        .i_clock(clk), .i_reset(rst_n), .i_rx_done(rx_done), .i_rx_data(rx_data),
        .o_pm_wr_en(b_wr), .o_pm_addr(b_addr), .o_pm_data(b_data),
        .o_busy(b_busy), .o_load_done(b_done), .o_error(b_err)
    );

    // writes seen on the small instance
    logic [1:0]  wq_addr[$];
    logic [15:0] wq_data[$];
    always @(negedge clk) begin
        if (b_wr) begin
            wq_addr.push_back(b_addr);
            wq_data.push_back(b_data);
        end
    end

    typedef struct {
        logic        rst;
        logic        rd;
        logic [7:0]  data;
        logic        wr;
        logic [10:0] addr;
        logic [15:0] pdata;
        logic        busy;
        logic        done;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic rd, logic [7:0] data, logic wr,
                                logic [10:0] addr, logic [15:0] pdata,
                                logic busy, logic done, logic err);
        vec_t v;
        v.rst = rst; v.rd = rd; v.data = data; v.wr = wr; v.addr = addr;
        v.pdata = pdata; v.busy = busy; v.done = done; v.err = err;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic cycle(logic rst, logic rd, logic [7:0] data);
        rst_n   = rst;
        rx_done = rd;
        rx_data = data;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(logic [15:0] w);
        cycle(1'b1, 1'b1, w[15:8]);
        cycle(1'b1, 1'b1, w[7:0]);
    endtask

    task automatic clear_q();
        wq_addr.delete();
        wq_data.delete();
    endtask

    initial begin
        logic [15:0] words[$];
        logic [15:0] exp_data[$];
        int          exp_n;
        logic        exp_done, exp_err, exp_busy;
        logic [15:0] w;
        logic [4:0]  op;
        int          r, nw, n;

        rst_n = 1'b0; rx_done = 1'b0; rx_data = 8'h00;

        // reset with strobes active
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0,1,8'hAA, 0,0,16'h0,0,0,0));
        // 18 05, 28 07, 00 00, then ignored bytes
        vecs.push_back(mk(1,1,8'h18, 0,0,16'h0000,1,0,0));
        vecs.push_back(mk(1,1,8'h05, 1,0,16'h1805,1,0,0));
        vecs.push_back(mk(1,0,8'h00, 0,0,16'h1805,1,0,0));
        vecs.push_back(mk(1,1,8'h28, 0,0,16'h1805,1,0,0));
        vecs.push_back(mk(1,1,8'h07, 1,1,16'h2807,1,0,0));
        vecs.push_back(mk(1,1,8'h00, 0,1,16'h2807,1,0,0));
        vecs.push_back(mk(1,1,8'h00, 1,2,16'h0000,0,1,0));
        vecs.push_back(mk(1,1,8'h55, 0,2,16'h0000,0,1,0));
        vecs.push_back(mk(1,1,8'h66, 0,2,16'h0000,0,1,0));
        vecs.push_back(mk(1,1,8'h77, 0,2,16'h0000,0,1,0));
        // back-to-back strobes
        vecs.push_back(mk(0,0,8'h00, 0,0,16'h0000,0,0,0));
        vecs.push_back(mk(1,1,8'h38, 0,0,16'h0000,1,0,0));
        vecs.push_back(mk(1,1,8'h01, 1,0,16'h3801,1,0,0));
        vecs.push_back(mk(1,1,8'h00, 0,0,16'h3801,1,0,0));
        vecs.push_back(mk(1,1,8'h00, 1,1,16'h0000,0,1,0));
        vecs.push_back(mk(1,0,8'h00, 0,1,16'h0000,0,1,0));
        // reset after high byte only discards it
        vecs.push_back(mk(0,0,8'h00, 0,0,16'h0000,0,0,0));
        vecs.push_back(mk(1,1,8'h12, 0,0,16'h0000,1,0,0));
        vecs.push_back(mk(0,0,8'h00, 0,0,16'h0000,0,0,0));
        vecs.push_back(mk(1,1,8'h34, 0,0,16'h0000,1,0,0));
        vecs.push_back(mk(1,1,8'h56, 1,0,16'h3456,1,0,0));
        vecs.push_back(mk(1,0,8'h00, 0,0,16'h3456,1,0,0));
        // undefined opcode 0x4000 followed by HALT
        vecs.push_back(mk(0,0,8'h00, 0,0,16'h0000,0,0,0));
        vecs.push_back(mk(1,1,8'h40, 0,0,16'h0000,1,0,0));
`ifdef LOADER_OPCODE_CHECK_EN
        vecs.push_back(mk(1,1,8'h00, 0,0,16'h0000,0,0,1));
        vecs.push_back(mk(1,1,8'h00, 0,0,16'h0000,0,0,1));
        vecs.push_back(mk(1,1,8'h00, 0,0,16'h0000,0,0,1));
`else
        vecs.push_back(mk(1,1,8'h00, 1,0,16'h4000,1,0,0));
        vecs.push_back(mk(1,1,8'h00, 0,0,16'h4000,1,0,0));
        vecs.push_back(mk(1,1,8'h00, 1,1,16'h0000,0,1,0));
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].rst, vecs[i].rd, vecs[i].data);
            check($sformatf("vec%0d {wr,addr,data,busy,done,err}", i),
                  {1'b0, a_wr, a_addr, a_data, a_busy, a_done, a_err},
                  {1'b0, vecs[i].wr, vecs[i].addr, vecs[i].pdata,
                   vecs[i].busy, vecs[i].done, vecs[i].err});
        end

        // fill a 4-deep memory without HALT
        cycle(0, 0, 0); cycle(0, 0, 0);
        clear_q();
        for (int i = 0; i < 4; i++) begin
            send_word(16'h0801 + 16'(i) * 16'h0101);
            if (i == 3) check("full_err_with_last_write", {b_wr, b_err, b_busy}, 3'b110);
        end
        cycle(1, 0, 0);
        send_word(16'h0C05);
        cycle(1, 0, 0);
        check("full_nwrites", wq_addr.size(), 4);
        for (int i = 0; i < 4 && i < wq_addr.size(); i++)
            check($sformatf("full_wr%0d", i), {wq_addr[i], wq_data[i]},
                  {2'(i), 16'h0801 + 16'(i) * 16'h0101});
        check("full_flags", {b_err, b_done, b_busy}, 3'b100);

        // HALT in the last location
        cycle(0, 0, 0); cycle(0, 0, 0);
        clear_q();
        send_word(16'h0811); send_word(16'h0922); send_word(16'h0A33);
        send_word(16'h0044);
        check("halt_last_flags", {b_wr, b_addr, b_done, b_err}, {1'b1, 2'd3, 1'b1, 1'b0});
        cycle(1, 0, 0);
        check("halt_last_nwrites", wq_addr.size(), 4);

        // randomized streams on the 4-deep instance
        for (int it = 0; it < 40; it++) begin
            cycle(0, 0, 0); cycle(0, 0, 0);
            clear_q();
            words.delete();
            nw = $urandom_range(1, 7);
            for (int k = 0; k < nw; k++) begin
                r = $urandom_range(0, 15);
                if (r < 2)       op = 5'd0;
                else if (r < 13) op = 5'($urandom_range(1, 7));
                else             op = 5'($urandom_range(8, 31));
                w = {op, 11'($urandom_range(0, 2047))};
                words.push_back(w);
                cycle(1, 1, w[15:8]);
                repeat ($urandom_range(0, 2)) cycle(1, 0, 8'h00);
                cycle(1, 1, w[7:0]);
                repeat ($urandom_range(0, 2)) cycle(1, 0, 8'h00);
            end
            repeat (3) cycle(1, 0, 0);

            // model: each word goes to the next address until HALT, a refused
            // opcode, or the last of the four locations has been used
            exp_data.delete();
            exp_done = 1'b0; exp_err = 1'b0; exp_busy = 1'b1;
            foreach (words[k]) begin
                if (exp_done || exp_err) break;
`ifdef LOADER_OPCODE_CHECK_EN
                if (words[k][15:11] > 5'd7) begin
                    exp_err = 1'b1;
                    break;
                end
`endif
                exp_data.push_back(words[k]);
                if (words[k][15:11] == 5'd0) exp_done = 1'b1;
                else if (exp_data.size() == 4) exp_err = 1'b1;
            end
            if (exp_done || exp_err) exp_busy = 1'b0;
            exp_n = exp_data.size();

            check($sformatf("rnd%0d_nwrites", it), wq_addr.size(), exp_n);
            n = (wq_addr.size() < exp_n) ? wq_addr.size() : exp_n;
            for (int k = 0; k < n; k++)
                check($sformatf("rnd%0d_wr%0d", it, k), {wq_addr[k], wq_data[k]},
                      {2'(k), exp_data[k]});
            check($sformatf("rnd%0d_flags", it), {b_busy, b_done, b_err},
                  {exp_busy, exp_done, exp_err});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
